// File: rtl/matrix_tile_scheduler_pkg.sv
// Shared types for the matrix tile scheduler: FSM state encoding, default
// dimensions and the index-width helper.
package matrix_tile_scheduler_pkg;

    localparam int unsigned MMS_DEF_N = 8;
    localparam int unsigned MMS_DEF_M = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_NEXT,
        ST_DONE
    } mms_state_e;

    // Tile index width; a single tile per dimension still needs a 1-bit index
    function automatic int unsigned width_min1(input int unsigned v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/matrix_tile_scheduler_if.sv
// Host, multiplier and result-memory signals of the tile scheduler.
// slave is the scheduler's view, master the surrounding environment's.
interface matrix_tile_scheduler_if
    import matrix_tile_scheduler_pkg::*;
#(
    parameter int unsigned n = MMS_DEF_N,
    parameter int unsigned m = MMS_DEF_M
);
    localparam int unsigned m_len = $clog2(m);
    localparam int unsigned n_len = $clog2(n);
    localparam int unsigned T     = n / m;
    localparam int unsigned T_len = width_min1(T);

    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic [T_len-1:0] tile_row;
    logic [T_len-1:0] tile_col;
    logic             mul_rst;
    logic             mul_start;
    logic             mul_done;
    logic [m_len-1:0] mul_a_i;
    logic [m_len-1:0] mul_b_j;
    logic [m_len-1:0] mul_z_i;
    logic [m_len-1:0] mul_z_j;
    logic [31:0]      mul_z_out;
    logic             mul_z_stb;
    logic             mul_z_ack;
    logic [n_len-1:0] a_row;
    logic [n_len-1:0] b_col;
    logic [n_len-1:0] z_row;
    logic [n_len-1:0] z_col;
    logic [31:0]      z_wr_data;
    logic             z_wr_en;
    logic             z_wr_ready;
    logic [31:0]      cycle_count;

    modport slave (
        input  start, abort, mul_done, mul_a_i, mul_b_j, mul_z_i, mul_z_j,
               mul_z_out, mul_z_stb, z_wr_ready,
        output busy, done, tile_row, tile_col, mul_rst, mul_start, mul_z_ack,
               a_row, b_col, z_row, z_col, z_wr_data, z_wr_en, cycle_count
    );

    modport master (
        output start, abort, mul_done, mul_a_i, mul_b_j, mul_z_i, mul_z_j,
               mul_z_out, mul_z_stb, z_wr_ready,
        input  busy, done, tile_row, tile_col, mul_rst, mul_start, mul_z_ack,
               a_row, b_col, z_row, z_col, z_wr_data, z_wr_en, cycle_count
    );

endinterface

// File: rtl/matrix_tile_scheduler_tile_index_counter.sv
// Row-major (ti,tj) tile walker: clear, advance, and a flag marking the last tile.
module tile_index_counter
    import matrix_tile_scheduler_pkg::*;
#(
    parameter int unsigned T     = 2,
    parameter int unsigned T_len = width_min1(T)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [T_len-1:0] ti_o,
    output logic [T_len-1:0] tj_o,
    output logic             last_tile_o
);
    localparam logic [T_len-1:0] LAST = T_len'(T - 1);

    logic [T_len-1:0] ti_q;
    logic [T_len-1:0] tj_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ti_q <= '0;
            tj_q <= '0;
        end else if (clear_i) begin
            ti_q <= '0;
            tj_q <= '0;
        end else if (advance_i) begin
            if (tj_q != LAST) begin
                tj_q <= tj_q + T_len'(1);
            end else begin
                tj_q <= '0;
                if (ti_q != LAST) ti_q <= ti_q + T_len'(1);
            end
        end
    end

    assign ti_o        = ti_q;
    assign tj_o        = tj_q;
    assign last_tile_o = (ti_q == LAST) && (tj_q == LAST);

endmodule

// File: rtl/matrix_tile_scheduler.sv
// Runs one multiplier over every m x m tile of an n x n product, offsetting addresses per tile.
// Define MMS_PERF_CNT_EN to build the busy-cycle counter behind cycle_count.
module matrix_tile_scheduler
    import matrix_tile_scheduler_pkg::*;
#(
    parameter int unsigned n = MMS_DEF_N,
    parameter int unsigned m = MMS_DEF_M
) (
    input  logic                   clk,
    input  logic                   rst,
    matrix_tile_scheduler_if.slave bus
);
    localparam int unsigned n_len = $clog2(n);
    localparam int unsigned T     = n / m;
    localparam int unsigned T_len = width_min1(T);
    localparam logic [n_len-1:0] M_STEP = n_len'(m);

    if ((n % m) != 0) begin : g_dim_check
        $error("matrix_tile_scheduler: n (%0d) must be a multiple of m (%0d)", n, m);
    end

    mms_state_e       state_q, state_d;
    logic             busy_q, done_q, mul_rst_q, mul_start_q;
    logic [T_len-1:0] ti, tj;
    logic             last_tile;
    logic             start_ok;
    logic             idx_clear;
    logic             idx_advance;
    logic             z_wr_en;
    logic [n_len-1:0] row_base, col_base;

    assign start_ok    = (state_q == ST_IDLE) && bus.start && !bus.abort;
    assign idx_clear   = start_ok || bus.abort;
    assign idx_advance = (state_q == ST_NEXT) && !last_tile && !bus.abort;

    tile_index_counter #(
        .T     (T),
        .T_len (T_len)
    ) u_idx (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (idx_clear),
        .advance_i   (idx_advance),
        .ti_o        (ti),
        .tj_o        (tj),
        .last_tile_o (last_tile)
    );

    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (bus.start) state_d = ST_LAUNCH;
                ST_LAUNCH: state_d = ST_RUN;
                ST_RUN:    if (bus.mul_done) state_d = ST_NEXT;
                ST_NEXT:   state_d = last_tile ? ST_DONE : ST_LAUNCH;
                ST_DONE:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they match a Moore decode of state_q
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mul_rst_q   <= 1'b1;
            mul_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
            mul_rst_q   <= (state_d != ST_RUN);
            mul_start_q <= (state_d == ST_RUN);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mul_rst   = mul_rst_q;
    assign bus.mul_start = mul_start_q;
    assign bus.tile_row  = ti;
    assign bus.tile_col  = tj;

    assign row_base  = n_len'(ti) * M_STEP;
    assign col_base  = n_len'(tj) * M_STEP;
    assign bus.a_row = row_base + n_len'(bus.mul_a_i);
    assign bus.b_col = col_base + n_len'(bus.mul_b_j);
    assign bus.z_row = row_base + n_len'(bus.mul_z_i);
    assign bus.z_col = col_base + n_len'(bus.mul_z_j);

    assign z_wr_en       = bus.mul_z_stb && (state_q == ST_RUN);
    assign bus.z_wr_en   = z_wr_en;
    assign bus.z_wr_data = bus.mul_z_out;
    assign bus.mul_z_ack = z_wr_en && bus.z_wr_ready;

`ifdef MMS_PERF_CNT_EN
    logic [31:0] cycle_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count_q <= '0;
        end else if (start_ok) begin
            cycle_count_q <= '0;
        end else if (busy_q && (cycle_count_q != '1)) begin
            cycle_count_q <= cycle_count_q + 32'd1;
        end
    end

    assign bus.cycle_count = cycle_count_q;
`else
    assign bus.cycle_count = '0;
`endif

endmodule

// File: tb/tb_matrix_tile_scheduler.sv
// Self-checking bench for matrix_tile_scheduler (n=8, m=4) with a behavioural multiplier.
// Build with MMS_PERF_CNT_EN defined to check the busy-cycle counter.
module tb_matrix_tile_scheduler;
    localparam int unsigned N   = 8;
    localparam int unsigned M   = 4;
    localparam int unsigned LAT = 20;

    typedef struct packed {
        logic r;
        logic c;
    } tile_t;

    typedef struct packed {
        logic [2:0]  r;
        logic [2:0]  c;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    matrix_tile_scheduler_if #(.n(N), .m(M)) intf ();

    matrix_tile_scheduler #(.n(N), .m(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.slave)
    );

    int total = 0;
    int bad   = 0;

    tile_t tile_q[$];
    wr_t   wr_q[$];

    // Multiplier model: mul_done rises LAT cycles after mul_start, cleared by mul_rst
    int unsigned mdl_lat = LAT;
    int unsigned mdl_cnt;
    logic        mdl_done;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdl_cnt  <= 0;
            mdl_done <= 1'b0;
        end else if (intf.mul_rst) begin
            mdl_cnt  <= 0;
            mdl_done <= 1'b0;
        end else if (intf.mul_start) begin
            if (mdl_cnt == mdl_lat - 1) mdl_done <= 1'b1;
            mdl_cnt <= mdl_cnt + 1;
        end
    end

    assign intf.mul_done = mdl_done;

    task automatic idle_inputs();
        intf.start      = 1'b0;
        intf.abort      = 1'b0;
        intf.mul_a_i    = '0;
        intf.mul_b_j    = '0;
        intf.mul_z_i    = '0;
        intf.mul_z_j    = '0;
        intf.mul_z_out  = '0;
        intf.mul_z_stb  = 1'b0;
        intf.z_wr_ready = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        intf.start = 1'b1;
        @(negedge clk);
        intf.start = 1'b0;
    endtask

    task automatic abort_to_idle();
        @(negedge clk);
        intf.abort = 1'b1;
        @(negedge clk);
        intf.abort = 1'b0;
    endtask

    // Walk forward (short multiplier latency) to the first RUN cycle of tile (r,c), then hold there
    task automatic run_to_tile(input logic r, input logic c, output logic ok);
        ok = 1'b0;
        mdl_lat = 4;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (intf.mul_start === 1'b1 && intf.tile_row === r && intf.tile_col === c) ok = 1'b1;
            else @(negedge clk);
        end
        mdl_lat = 100000;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL reach_tile got=none want=(%0d,%0d) within 400 cycles", r, c);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (intf.busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", intf.busy); end
        total++; if (intf.done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b want=0", intf.done); end
        total++; if (intf.mul_rst !== 1'b1)   begin bad++; $display("FAIL reset_mul_rst got=%b want=1", intf.mul_rst); end
        total++; if (intf.mul_start !== 1'b0) begin bad++; $display("FAIL reset_mul_start got=%b want=0", intf.mul_start); end
        total++; if (intf.tile_row !== 1'b0 || intf.tile_col !== 1'b0)
            begin bad++; $display("FAIL reset_tile got=(%0d,%0d) want=(0,0)", intf.tile_row, intf.tile_col); end
        total++; if (intf.cycle_count !== 32'd0) begin bad++; $display("FAIL reset_cycle_count got=%0d want=0", intf.cycle_count); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (intf.busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%b want=0", intf.busy); end
    endtask

    task automatic test_tile_sequence();
        logic prev_start, prev_done, timed_out;
        int   launches, dones, last_done, done_cyc;
        tile_t exp_t;
        idle_inputs();
        mdl_lat = LAT;
        tile_q.delete();
        tile_q.push_back('{r: 1'b0, c: 1'b0});
        tile_q.push_back('{r: 1'b0, c: 1'b1});
        tile_q.push_back('{r: 1'b1, c: 1'b0});
        tile_q.push_back('{r: 1'b1, c: 1'b1});
        launches = 0; dones = 0; last_done = 0; done_cyc = 0; timed_out = 1'b1;
        prev_start = 1'b0; prev_done = 1'b0;
        @(negedge clk);
        intf.start = 1'b1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (i == 1) intf.start = 1'b0;
            if (intf.mul_done && !prev_done) last_done = i;
            if (intf.mul_start && !prev_start) begin
                launches++;
                total++;
                if (tile_q.size() == 0) begin
                    bad++; $display("FAIL seq_launch got=extra launch (%0d,%0d) want=none", intf.tile_row, intf.tile_col);
                end else begin
                    exp_t = tile_q.pop_front();
                    if (intf.tile_row !== exp_t.r || intf.tile_col !== exp_t.c) begin
                        bad++; $display("FAIL seq_launch got=(%0d,%0d) want=(%0d,%0d)", intf.tile_row, intf.tile_col, exp_t.r, exp_t.c);
                    end
                end
                total++;
                if (launches == 1) begin
                    if (i != 2) begin bad++; $display("FAIL start_to_mul_start got=%0d want=2", i); end
                end else if (i - last_done != 3) begin
                    bad++; $display("FAIL done_to_mul_start got=%0d want=3", i - last_done);
                end
            end
            if (intf.done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    done_cyc = i;
                    total++;
                    if (i - last_done != 2) begin bad++; $display("FAIL last_done_to_done got=%0d want=2", i - last_done); end
                end
            end
`ifndef MMS_PERF_CNT_EN
            total++;
            if (intf.cycle_count !== 32'd0) begin bad++; $display("FAIL cycle_count_off got=%0d want=0", intf.cycle_count); end
`endif
            if (done_cyc > 0 && i == done_cyc + 1) begin
                total++;
                if (intf.busy !== 1'b0) begin bad++; $display("FAIL busy_after_done got=%b want=0", intf.busy); end
`ifdef MMS_PERF_CNT_EN
                total++;
                if (intf.cycle_count !== 32'(4 * (LAT + 3) + 1))
                    begin bad++; $display("FAIL cycle_count got=%0d want=%0d", intf.cycle_count, 4 * (LAT + 3) + 1); end
`endif
            end
            if (done_cyc > 0 && i == done_cyc + 4) begin
                timed_out = 1'b0;
                break;
            end
            prev_start = intf.mul_start;
            prev_done  = intf.mul_done;
        end
        total++; if (timed_out) begin bad++; $display("FAIL seq_timeout got=no done want=done within 400 cycles"); end
        total++; if (dones != 1) begin bad++; $display("FAIL done_pulses got=%0d want=1", dones); end
        total++; if (launches != 4) begin bad++; $display("FAIL launch_count got=%0d want=4", launches); end
        total++; if (intf.busy !== 1'b0) begin bad++; $display("FAIL busy_idle got=%b want=0", intf.busy); end
    endtask

    task automatic test_addresses();
        logic ok;
        logic [2:0]  exp_a, exp_b;
        logic [31:0] data;
        idle_inputs();
        pulse_start();
        run_to_tile(1'b1, 1'b0, ok);
        if (ok) begin
            for (int k = 0; k < 4; k++) begin
                data = $urandom;
                intf.mul_z_i   = 2'd2;
                intf.mul_z_j   = 2'd3;
                intf.mul_a_i   = 2'(k);
                intf.mul_b_j   = 2'(3 - k);
                intf.mul_z_out = data;
                exp_a = 3'(4 + k);
                exp_b = 3'(3 - k);
                #1;
                total++; if (intf.z_row !== 3'd6) begin bad++; $display("FAIL z_row got=%0d want=6", intf.z_row); end
                total++; if (intf.z_col !== 3'd3) begin bad++; $display("FAIL z_col got=%0d want=3", intf.z_col); end
                total++; if (intf.a_row !== exp_a) begin bad++; $display("FAIL a_row got=%0d want=%0d", intf.a_row, exp_a); end
                total++; if (intf.b_col !== exp_b) begin bad++; $display("FAIL b_col got=%0d want=%0d", intf.b_col, exp_b); end
                total++; if (intf.z_wr_data !== data) begin bad++; $display("FAIL z_wr_data got=%h want=%h", intf.z_wr_data, data); end
                @(negedge clk);
            end
        end
        abort_to_idle();
        idle_inputs();
    endtask

    task automatic test_backpressure();
        logic ok;
        int   writes;
        wr_t  exp_w, obs_w;
        idle_inputs();
        pulse_start();
        run_to_tile(1'b0, 1'b0, ok);
        writes = 0;
        intf.mul_z_i    = 2'd1;
        intf.mul_z_j    = 2'd2;
        intf.mul_z_out  = 32'hCAFE_0001;
        intf.mul_z_stb  = 1'b1;
        intf.z_wr_ready = 1'b0;
        wr_q.push_back('{r: 3'd1, c: 3'd2, d: 32'hCAFE_0001});
        for (int k = 0; k < 5; k++) begin
            #1;
            if (intf.mul_z_ack === 1'b1) writes++;
            total++; if (intf.mul_z_ack !== 1'b0) begin bad++; $display("FAIL stall_ack cycle=%0d got=%b want=0", k, intf.mul_z_ack); end
            @(negedge clk);
        end
        intf.z_wr_ready = 1'b1;
        #1;
        total++; if (intf.mul_z_ack !== 1'b1) begin bad++; $display("FAIL ready_ack got=%b want=1", intf.mul_z_ack); end
        if (intf.mul_z_ack === 1'b1 && intf.z_wr_en === 1'b1) begin
            writes++;
            obs_w.r = intf.z_row;
            obs_w.c = intf.z_col;
            obs_w.d = intf.z_wr_data;
            exp_w = wr_q.pop_front();
            total++;
            if (obs_w !== exp_w) begin
                bad++; $display("FAIL z_write got=(%0d,%0d,%h) want=(%0d,%0d,%h)", obs_w.r, obs_w.c, obs_w.d, exp_w.r, exp_w.c, exp_w.d);
            end
        end
        @(negedge clk);
        intf.mul_z_stb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (intf.mul_z_ack === 1'b1) writes++;
            total++; if (intf.mul_z_ack !== 1'b0) begin bad++; $display("FAIL post_ack cycle=%0d got=%b want=0", k, intf.mul_z_ack); end
            @(negedge clk);
        end
        total++; if (writes != 1) begin bad++; $display("FAIL write_count got=%0d want=1", writes); end
        total++; if (wr_q.size() != 0) begin bad++; $display("FAIL write_pending got=%0d want=0", wr_q.size()); end
        abort_to_idle();
        intf.mul_z_stb = 1'b1;
        #1;
        total++; if (intf.z_wr_en !== 1'b0 || intf.mul_z_ack !== 1'b0)
            begin bad++; $display("FAIL idle_strobe got=en%b/ack%b want=en0/ack0", intf.z_wr_en, intf.mul_z_ack); end
        pulse_start();
        #1;
        total++; if (intf.z_wr_en !== 1'b0 || intf.mul_z_ack !== 1'b0)
            begin bad++; $display("FAIL launch_strobe got=en%b/ack%b want=en0/ack0", intf.z_wr_en, intf.mul_z_ack); end
        abort_to_idle();
        idle_inputs();
    endtask

    task automatic test_abort();
        logic  ok, seen;
        tile_t exp_t;
        idle_inputs();
        pulse_start();
        run_to_tile(1'b0, 1'b1, ok);
        @(negedge clk);
        intf.abort = 1'b1;
        @(negedge clk);
        intf.abort = 1'b0;
        total++; if (intf.busy !== 1'b0)    begin bad++; $display("FAIL abort_busy got=%b want=0", intf.busy); end
        total++; if (intf.mul_rst !== 1'b1) begin bad++; $display("FAIL abort_mul_rst got=%b want=1", intf.mul_rst); end
        total++; if (intf.tile_row !== 1'b0 || intf.tile_col !== 1'b0)
            begin bad++; $display("FAIL abort_tile got=(%0d,%0d) want=(0,0)", intf.tile_row, intf.tile_col); end
        for (int k = 0; k < 4; k++) begin
            total++; if (intf.done !== 1'b0) begin bad++; $display("FAIL abort_done cycle=%0d got=%b want=0", k, intf.done); end
            @(negedge clk);
        end
        tile_q.push_back('{r: 1'b0, c: 1'b0});
        pulse_start();
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            @(negedge clk);
            if (intf.mul_start === 1'b1) begin
                seen = 1'b1;
                exp_t = tile_q.pop_front();
                total++;
                if (intf.tile_row !== exp_t.r || intf.tile_col !== exp_t.c)
                    begin bad++; $display("FAIL restart_tile got=(%0d,%0d) want=(%0d,%0d)", intf.tile_row, intf.tile_col, exp_t.r, exp_t.c); end
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL restart_launch got=none want=mul_start within 5 cycles"); end
        abort_to_idle();
        @(negedge clk);
        intf.start = 1'b1;
        intf.abort = 1'b1;
        @(negedge clk);
        intf.start = 1'b0;
        intf.abort = 1'b0;
        total++; if (intf.busy !== 1'b0) begin bad++; $display("FAIL start_abort_busy got=%b want=0", intf.busy); end
        @(negedge clk);
        total++; if (intf.busy !== 1'b0 || intf.mul_rst !== 1'b1)
            begin bad++; $display("FAIL start_abort_idle got=busy%b/rst%b want=busy0/rst1", intf.busy, intf.mul_rst); end
    endtask

    task automatic test_async_reset();
        logic ok;
        idle_inputs();
        pulse_start();
        run_to_tile(1'b1, 1'b1, ok);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total++; if (intf.busy !== 1'b0)      begin bad++; $display("FAIL arst_busy got=%b want=0", intf.busy); end
        total++; if (intf.done !== 1'b0)      begin bad++; $display("FAIL arst_done got=%b want=0", intf.done); end
        total++; if (intf.mul_rst !== 1'b1)   begin bad++; $display("FAIL arst_mul_rst got=%b want=1", intf.mul_rst); end
        total++; if (intf.mul_start !== 1'b0) begin bad++; $display("FAIL arst_mul_start got=%b want=0", intf.mul_start); end
        total++; if (intf.tile_row !== 1'b0 || intf.tile_col !== 1'b0)
            begin bad++; $display("FAIL arst_tile got=(%0d,%0d) want=(0,0)", intf.tile_row, intf.tile_col); end
        total++; if (intf.cycle_count !== 32'd0) begin bad++; $display("FAIL arst_cycle_count got=%0d want=0", intf.cycle_count); end
        @(negedge clk);
        rst = 1'b1;
        pulse_start();
        run_to_tile(1'b0, 1'b1, ok);
        @(negedge clk);
        intf.start = 1'b1;
        @(negedge clk);
        intf.start = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (intf.busy !== 1'b1 || intf.mul_start !== 1'b1)
            begin bad++; $display("FAIL busy_start_state got=busy%b/start%b want=busy1/start1", intf.busy, intf.mul_start); end
        total++; if (intf.tile_row !== 1'b0 || intf.tile_col !== 1'b1)
            begin bad++; $display("FAIL busy_start_tile got=(%0d,%0d) want=(0,1)", intf.tile_row, intf.tile_col); end
        abort_to_idle();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_tile_sequence();
        test_addresses();
        test_backpressure();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
